// File: rtl/pipe_hazard_ctrl.sv
// Five-stage MIPS pipeline sequencer: run/halt FSM, load-use stall, EXE forwarding selects.
// Define PERF_CNT_EN to add saturating stall_cnt / flush_cnt performance counters.
module pipe_hazard_ctrl #(
  parameter int REG_AW = 5
`ifdef PERF_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt_req,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_wreg,
  input  logic              id_m2reg,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_branch_taken,
  output logic              pc_we,
  output logic              ifid_we,
  output logic              ifid_flush,
  output logic              idexe_bubble,
  output logic [1:0]        fwda,
  output logic [1:0]        fwdb,
  output logic              running,
  output logic              halted
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALTED} state_t;

  typedef struct packed {
    logic              valid;
    logic              wreg;
    logic              m2reg;
    logic [REG_AW-1:0] dest;
  } slot_t;

  state_t      state_q, state_d;
  logic [1:0]  drain_q, drain_d;
  slot_t       exe_q, exe_d, mem_q, mem_d;
  logic [1:0]  fwda_q, fwda_d, fwdb_q, fwdb_d;
  logic        hazard;
  logic        issue;

  // EXE beats MEM; a load in EXE cannot forward yet, so it falls through to MEM or the regfile.
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src,
                                         input slot_t exe, input slot_t mem);
    if (exe.valid && exe.wreg && !exe.m2reg && (exe.dest != '0) && (exe.dest == src))
      fwd_sel = 2'b01;
    else if (mem.valid && mem.wreg && (mem.dest != '0) && (mem.dest == src))
      fwd_sel = mem.m2reg ? 2'b11 : 2'b10;
    else
      fwd_sel = 2'b00;
  endfunction

  always_comb begin
    hazard = id_valid && exe_q.valid && exe_q.wreg && exe_q.m2reg && (exe_q.dest != '0) &&
             ((id_use_rs && (id_rs == exe_q.dest)) || (id_use_rt && (id_rt == exe_q.dest)));
  end

  always_comb begin
    state_d      = state_q;
    drain_d      = drain_q;
    pc_we        = 1'b0;
    ifid_we      = 1'b0;
    ifid_flush   = 1'b1;
    idexe_bubble = 1'b1;
    case (state_q)
      IDLE, HALTED: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        if (hazard) begin
          // Stall overrides both a taken branch and a halt request; both re-evaluate next cycle.
          ifid_flush = 1'b0;
        end else if (halt_req) begin
          idexe_bubble = ~id_valid;
          pc_we        = id_branch_taken;
          state_d      = DRAIN;
          drain_d      = 2'd3;
        end else begin
          pc_we        = 1'b1;
          ifid_we      = 1'b1;
          idexe_bubble = ~id_valid;
          ifid_flush   = id_branch_taken;
        end
      end
      DRAIN: begin
        drain_d = drain_q - 2'd1;
        if (drain_q == 2'd1) state_d = HALTED;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    issue  = id_valid && !idexe_bubble && (state_q == RUN);
    mem_d  = exe_q;
    exe_d  = '0;
    fwda_d = 2'b00;
    fwdb_d = 2'b00;
    if (issue) begin
      exe_d  = '{valid: 1'b1, wreg: id_wreg, m2reg: id_m2reg, dest: id_dest};
      fwda_d = fwd_sel(id_rs, exe_q, mem_q);
      fwdb_d = fwd_sel(id_rt, exe_q, mem_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      drain_q <= 2'd0;
      exe_q   <= '0;
      mem_q   <= '0;
      fwda_q  <= 2'b00;
      fwdb_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      exe_q   <= exe_d;
      mem_q   <= mem_d;
      fwda_q  <= fwda_d;
      fwdb_q  <= fwdb_d;
    end
  end

  assign fwda    = fwda_q;
  assign fwdb    = fwdb_q;
  assign running = (state_q == RUN);
  assign halted  = (state_q == HALTED);

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  // Counters only advance in RUN and stick at all-ones instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (state_q == RUN) begin
      if (hazard && (stall_cnt_q != '1))
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (!hazard && id_branch_taken && (flush_cnt_q != '1))
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed instruction stream checked every cycle against
// an instruction-history model, plus hand-computed literal expectations at key points.
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0, halt_req = 1'b0, id_valid = 1'b0;
   logic [4:0] id_rs = '0, id_rt = '0, id_dest = '0;
   logic       id_use_rs = 1'b0, id_use_rt = 1'b0, id_wreg = 1'b0, id_m2reg = 1'b0;
   logic       id_branch_taken = 1'b0;
   logic       pc_we, ifid_we, ifid_flush, idexe_bubble, running, halted;
   logic [1:0] fwda, fwdb;
`ifdef PERF_CNT_EN
   logic [15:0] stall_cnt, flush_cnt;
`endif

   int checks = 0;
   int errors = 0;

   pipe_hazard_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .halt_req(halt_req), .id_valid(id_valid),
      .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .id_wreg(id_wreg), .id_m2reg(id_m2reg), .id_dest(id_dest),
      .id_branch_taken(id_branch_taken), .pc_we(pc_we), .ifid_we(ifid_we),
      .ifid_flush(ifid_flush), .idexe_bubble(idexe_bubble), .fwda(fwda), .fwdb(fwdb),
      .running(running), .halted(halted)
`ifdef PERF_CNT_EN
      , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
   );

   always #10 clk = ~clk;

   // One record per clock edge: what entered EXE on that edge (invalid when nothing issued).
   typedef struct {
      bit v;
      bit w;
      bit ld;
      int d;
      int rs;
      int rt;
   } rec_t;

   localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_HALTED = 3;

   rec_t hist[$];
   int   m_mode = M_IDLE;
   int   m_left = 0;

   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void modelClear();
      rec_t inv;
      inv = '{default: 0};
      hist.delete();
      for (int i = 0; i < 3; i++) hist.push_back(inv);
   endfunction

   // hist[2] sits in EXE now, hist[1] in MEM; when hist[2] was in ID, hist[1] was in EXE and hist[0] in MEM.
   function automatic bit modelHazard();
      rec_t e;
      e = hist[2];
      return id_valid && e.v && e.w && e.ld && (e.d != 0) &&
             ((id_use_rs && (int'(id_rs) == e.d)) || (id_use_rt && (int'(id_rt) == e.d)));
   endfunction

   function automatic int modelFwd(input int src);
      rec_t x, m;
      if (!hist[2].v) return 0;
      x = hist[1];
      m = hist[0];
      if (x.v && x.w && !x.ld && (x.d != 0) && (x.d == src)) return 1;
      if (m.v && m.w && (m.d != 0) && (m.d == src)) return m.ld ? 3 : 2;
      return 0;
   endfunction

   // Model state advance on each clock edge or asynchronous reset.
   initial begin
      bit   haz, iss;
      rec_t r;
      modelClear();
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            m_mode = M_IDLE;
            m_left = 0;
            modelClear();
         end else begin
            haz = modelHazard();
            iss = (m_mode == M_RUN) && id_valid && !haz;
            r = '{default: 0};
            if (iss) begin
               r.v  = 1'b1;
               r.w  = id_wreg;
               r.ld = id_m2reg;
               r.d  = int'(id_dest);
               r.rs = int'(id_rs);
               r.rt = int'(id_rt);
            end
            hist.push_back(r);
            void'(hist.pop_front());
            case (m_mode)
               M_IDLE, M_HALTED: if (start) m_mode = M_RUN;
               M_RUN: if (!haz && halt_req) begin
                  m_mode = M_DRAIN;
                  m_left = 3;
               end
               default: begin
                  if (m_left == 1) m_mode = M_HALTED;
                  m_left = m_left - 1;
               end
            endcase
         end
      end
   end

   // Compare every output against the model in the middle of every cycle.
   always @(negedge clk) begin
      int e_pc, e_we, e_fl, e_bb;
      bit haz;
      haz  = modelHazard();
      e_pc = 0; e_we = 0; e_fl = 1; e_bb = 1;
      if (m_mode == M_RUN) begin
         if (haz) begin
            e_fl = 0;
         end else if (halt_req) begin
            e_pc = int'(id_branch_taken);
            e_bb = int'(!id_valid);
         end else begin
            e_pc = 1; e_we = 1;
            e_fl = int'(id_branch_taken);
            e_bb = int'(!id_valid);
         end
      end
      checkOutput("m_pc_we", int'(pc_we), e_pc);
      checkOutput("m_ifid_we", int'(ifid_we), e_we);
      checkOutput("m_ifid_flush", int'(ifid_flush), e_fl);
      checkOutput("m_idexe_bubble", int'(idexe_bubble), e_bb);
      checkOutput("m_fwda", int'(fwda), modelFwd(hist[2].rs));
      checkOutput("m_fwdb", int'(fwdb), modelFwd(hist[2].rt));
      checkOutput("m_running", int'(running), int'(m_mode == M_RUN));
      checkOutput("m_halted", int'(halted), int'(m_mode == M_HALTED));
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic applyStimulus(input bit v, input logic [4:0] rs, input logic [4:0] rt,
                                input bit urs, input bit urt, input bit w, input bit ld,
                                input logic [4:0] dst, input bit br, input bit hlt, input bit st);
      id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
      id_wreg = w; id_m2reg = ld; id_dest = dst; id_branch_taken = br;
      halt_req = hlt; start = st;
      #3;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic nop();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_pc_we"}, int'(pc_we), 0);
      checkOutput({tag, "_ifid_we"}, int'(ifid_we), 0);
      checkOutput({tag, "_ifid_flush"}, int'(ifid_flush), 1);
      checkOutput({tag, "_idexe_bubble"}, int'(idexe_bubble), 1);
      checkOutput({tag, "_fwda"}, int'(fwda), 0);
      checkOutput({tag, "_fwdb"}, int'(fwdb), 0);
      checkOutput({tag, "_running"}, int'(running), 0);
      checkOutput({tag, "_halted"}, int'(halted), 0);
   endtask

   initial begin
      #1 rst = 1'b1;
      #2 checkResetOutputs("por");
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;

      nop();                                              checkOutput("idle_running", int'(running), 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);     tick();
      // lw $2,0($1)
      applyStimulus(1, 1, 0, 1, 0, 1, 1, 2, 0, 0, 0);
      checkOutput("start_running", int'(running), 1);
      checkOutput("lw_pc_we", int'(pc_we), 1);
      tick();
      // add $3,$2,$4 stalls once, then issues
      applyStimulus(1, 2, 4, 1, 1, 1, 0, 3, 0, 0, 0);
      checkOutput("lu_pc_we", int'(pc_we), 0);
      checkOutput("lu_ifid_we", int'(ifid_we), 0);
      checkOutput("lu_bubble", int'(idexe_bubble), 1);
      tick();
      applyStimulus(1, 2, 4, 1, 1, 1, 0, 3, 0, 0, 0);
      checkOutput("lu_release_pc_we", int'(pc_we), 1);
      checkOutput("lu_release_bubble", int'(idexe_bubble), 0);
      tick();
      // add $5,$6,$7 ; sub $8,$5,$5
      applyStimulus(1, 6, 7, 1, 1, 1, 0, 5, 0, 0, 0);
      checkOutput("lu_fwda_memdo", int'(fwda), 3);
      checkOutput("lu_fwdb_rf", int'(fwdb), 0);
      tick();
      applyStimulus(1, 5, 5, 1, 1, 1, 0, 8, 0, 0, 0);
      checkOutput("alu_nostall", int'(pc_we), 1);
      tick();
      nop();
      checkOutput("alu_fwda", int'(fwda), 1);
      checkOutput("alu_fwdb", int'(fwdb), 1);
      tick();
      // Two writers of $9, then a reader: EXE wins
      applyStimulus(1, 1, 1, 1, 1, 1, 0, 9, 0, 0, 0);     tick();
      applyStimulus(1, 2, 2, 1, 1, 1, 0, 9, 0, 0, 0);     tick();
      applyStimulus(1, 9, 9, 1, 1, 1, 0, 10, 0, 0, 0);    tick();
      nop();
      checkOutput("prio_fwda", int'(fwda), 1);
      checkOutput("prio_fwdb", int'(fwdb), 1);
      tick();
      // lw $0 then reader of $0: no stall, no forward
      applyStimulus(1, 1, 0, 1, 0, 1, 1, 0, 0, 0, 0);     tick();
      applyStimulus(1, 0, 0, 1, 1, 1, 0, 11, 0, 0, 0);
      checkOutput("r0_nostall", int'(pc_we), 1);
      tick();
      nop();
      checkOutput("r0_fwda", int'(fwda), 0);
      checkOutput("r0_fwdb", int'(fwdb), 0);
      tick();
      // Load-use with a taken branch: stall wins, flush on the retry
      applyStimulus(1, 1, 0, 1, 0, 1, 1, 12, 0, 0, 0);    tick();
      applyStimulus(1, 12, 0, 1, 0, 0, 0, 0, 1, 0, 0);
      checkOutput("br_stall_flush", int'(ifid_flush), 0);
      checkOutput("br_stall_pc_we", int'(pc_we), 0);
      tick();
      applyStimulus(1, 12, 0, 1, 0, 0, 0, 0, 1, 0, 0);
      checkOutput("br_retry_flush", int'(ifid_flush), 1);
      checkOutput("br_retry_pc_we", int'(pc_we), 1);
      tick();
      // Halt requested during a stall: deferred one cycle, then drain
      applyStimulus(1, 1, 0, 1, 0, 1, 1, 13, 0, 0, 0);    tick();
      applyStimulus(1, 13, 0, 1, 0, 1, 0, 14, 0, 1, 0);
      checkOutput("halt_defer_pc_we", int'(pc_we), 0);
      checkOutput("halt_defer_flush", int'(ifid_flush), 0);
      checkOutput("halt_defer_running", int'(running), 1);
      tick();
      applyStimulus(1, 13, 0, 1, 0, 1, 0, 14, 0, 1, 0);
      checkOutput("halt_flush", int'(ifid_flush), 1);
      checkOutput("halt_ifid_we", int'(ifid_we), 0);
      checkOutput("halt_pc_we", int'(pc_we), 0);
      checkOutput("halt_issue", int'(idexe_bubble), 0);
      tick();
      nop();
      checkOutput("drain1_running", int'(running), 0);
      checkOutput("drain1_halted", int'(halted), 0);
      tick();
      nop();                                              tick();
      nop();
      checkOutput("drain3_halted", int'(halted), 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      checkOutput("halted_flag", int'(halted), 1);
      checkOutput("halted_pc_we", int'(pc_we), 0);
      tick();
      applyStimulus(1, 1, 0, 1, 0, 1, 0, 15, 1, 0, 0);
      checkOutput("restart_running", int'(running), 1);
      checkOutput("restart_pc_we", int'(pc_we), 1);
      checkOutput("restart_br_flush", int'(ifid_flush), 1);
      tick();
      applyStimulus(1, 15, 0, 1, 0, 1, 0, 16, 0, 0, 0);
`ifdef PERF_CNT_EN
      checkOutput("perf_stall_cnt", int'(stall_cnt), 3);
      checkOutput("perf_flush_cnt", int'(flush_cnt), 2);
`endif
      tick();
      // Asynchronous reset mid-RUN while a forward is live
      applyStimulus(1, 1, 0, 1, 0, 1, 0, 17, 0, 0, 0);
      checkOutput("prerst_fwda", int'(fwda), 1);
      #1 rst = 1'b1;
      #1 checkResetOutputs("midrst");
`ifdef PERF_CNT_EN
      checkOutput("midrst_stall_cnt", int'(stall_cnt), 0);
`endif
      tick();
      rst = 1'b0;
      nop();
      checkOutput("postrst_running", int'(running), 0);
      checkOutput("postrst_flush", int'(ifid_flush), 1);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);     tick();
      nop();
      checkOutput("postrst_start_running", int'(running), 1);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencing controller for the five-stage MIPS datapath (IF, ID, EXE, MEM, WB).
- Owns run/halt sequencing and load-use stall detection. Drives the PC and IF/ID write enables, IF/ID flush and ID/EXE bubble injection, and the EXE-stage forwarding selects.
- Keeps its own shadow scoreboard (valid, wreg, m2reg, dest) of the instructions in EXE and MEM, fed from ID-stage decode each cycle.

Parameters:
- REG_AW, 5, register-number width.
- CNT_W, 16, perf-counter width (only with PERF_CNT_EN).

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  leave IDLE/HALTED and begin fetching.
- halt_req  in  1  level; request orderly drain to HALTED.
- id_valid  in  1  IF/ID holds a real instruction.
- id_rs  in  REG_AW  ID source register a.
- id_rt  in  REG_AW  ID source register b.
- id_use_rs  in  1  instruction reads rs.
- id_use_rt  in  1  instruction reads rt.
- id_wreg  in  1  instruction writes a register.
- id_m2reg  in  1  instruction is a load.
- id_dest  in  REG_AW  destination register (regrt mux output).
- id_branch_taken  in  1  branch resolved taken in ID.
- pc_we  out  1  PC register load enable.
- ifid_we  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID clears to invalid on next edge.
- idexe_bubble  out  1  ID/EXE loads a NOP (wreg=0, wmem=0).
- fwda  out  2  operand-a select: 00 regfile qa, 01 EXE ALU r, 10 MEM mr, 11 MEM do.
- fwdb  out  2  operand-b select, same encoding.
- running  out  1  state==RUN.
- halted  out  1  state==HALTED.

Behaviour:
- FSM states: IDLE, RUN, DRAIN, HALTED; 2-bit drain counter.
- Reset (async): state=IDLE, EXE/MEM slots invalid, drain counter 0.
- Reset output values: pc_we=0, ifid_we=0, ifid_flush=1, idexe_bubble=1, fwda=fwdb=00, running=0, halted=0.
- IDLE/HALTED: pc_we=0, ifid_we=0, ifid_flush=1, idexe_bubble=1.
- IDLE/HALTED transition: start=1 -> RUN on next edge.
- Shadow slots shift every edge in every state:
  - MEM <= EXE.
  - EXE <= ID info when the ID instruction issues; otherwise EXE <= invalid.
  - ID instruction issues only if id_valid & ~idexe_bubble & state==RUN.
- WB needs no tracking: the register file writes on negedge, so a same-cycle ID read sees the WB value.
- Load-use hazard (combinational), all terms required:
  - id_valid;
  - EXE.valid & EXE.wreg & EXE.m2reg;
  - EXE.dest != 0;
  - (id_use_rs & id_rs==EXE.dest) | (id_use_rt & id_rt==EXE.dest).
- RUN, hazard: pc_we=0, ifid_we=0, idexe_bubble=1, ifid_flush=0. Exactly one stall cycle per load-use pair.
- RUN, no hazard: pc_we=1, ifid_we=1, idexe_bubble=~id_valid.
- RUN, taken branch: ifid_flush=id_branch_taken.
- Stall and taken branch in the same cycle: stall wins, flush suppressed; the branch re-evaluates next cycle.
- Forwarding, per operand (rs->fwda, rt->fwdb), evaluated on the ID-stage registers and registered into EXE alongside ID/EXE:
  - EXE slot match (valid, wreg, dest!=0, non-load) -> 01.
  - Else MEM slot match with m2reg=0 -> 10; with m2reg=1 -> 11.
  - Else 00.
  - EXE has priority over MEM.
  - Register 0 never forwards and never stalls.
  - fwda/fwdb reset to 00 and load 00 on a bubble.
- Halt sequence:
  - halt_req is sampled only in a RUN cycle with no hazard. That cycle the ID instruction issues normally, ifid_flush=1, ifid_we=0, pc_we=id_branch_taken. Next state is DRAIN, drain counter=3.
  - halt_req in a stall cycle is deferred.
  - DRAIN: all enables 0, idexe_bubble=1, counter decrements; at 1 -> HALTED. EXE/MEM/WB are then empty.
  - On restart, PC holds the un-fetched address, so nothing is lost or duplicated.
- start and halt_req together in IDLE/HALTED: start wins; halt is then sampled per the RUN rules.
- rst mid-operation: immediate IDLE; slots cleared; no outputs carry pre-reset state.

Optional Feature:
- Macro PERF_CNT_EN.
- Defined:
  - Adds outputs stall_cnt and flush_cnt (out, CNT_W).
  - stall_cnt counts load-use stall cycles; flush_cnt counts RUN-state taken-branch flushes.
  - Both saturate at all-ones, clear on rst, and hold in IDLE/DRAIN/HALTED.
- Not defined: ports and counters are absent; all other behaviour identical.

Test Plan:
- Reset check: rst pulse mid-RUN -> outputs at reset values the same cycle, before any clock edge; IDLE after release; start -> running=1 next edge.
- Load-use stall: lw $2,0($1) then add $3,$2,$4 -> one cycle with pc_we=0, ifid_we=0, idexe_bubble=1. add then issues with fwda=11 (MEM do).
- ALU back-to-back: add $5,$6,$7 then sub $8,$5,$5 -> no stall; fwda=fwdb=01.
- Priority and register 0: two writers of $9 in EXE and MEM -> fwd=01. Dest $0 anywhere -> fwd=00 and no stall.
- Stall vs branch: load-use hazard with id_branch_taken=1 -> ifid_flush=0 that cycle; flush=1 the next cycle.
- Halt/restart: halt_req asserted during a stall -> deferred one cycle; then flush, 3 DRAIN cycles, halted=1; start resumes fetching at the held PC.
- PERF_CNT_EN only: 3 load-use stalls and 2 taken branches -> stall_cnt=3, flush_cnt=2.
